// File: rtl/axil_sram_slave.sv
// AXI4-Lite-style SRAM responder: word-addressed array behind independent read and write
// channels, each answering one outstanding request after a fixed programmable latency.
module axil_sram_slave #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            DEPTH_LOG2 = 16,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000),
    parameter int unsigned            RD_LAT     = 2,
    parameter int unsigned            WR_LAT     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [3:0]            wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("axil_sram_slave: DATA_WIDTH must be 32");
    end
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("axil_sram_slave: RD_LAT must be in 1..15");
    end
    if (WR_LAT < 1 || WR_LAT > 15) begin : g_bad_wr_lat
        $error("axil_sram_slave: WR_LAT must be in 1..15");
    end
    if (DEPTH_LOG2 + 2 > ADDR_WIDTH) begin : g_bad_depth
        $error("axil_sram_slave: array larger than the address space");
    end

    localparam int unsigned           WORDS       = 2 ** DEPTH_LOG2;
    localparam logic [ADDR_WIDTH:0]   SPAN        = (ADDR_WIDTH + 1)'(1) << (DEPTH_LOG2 + 2);
    localparam logic [3:0]            RD_CNT_INIT = 4'(RD_LAT - 1);
    localparam logic [3:0]            WR_CNT_INIT = 4'(WR_LAT - 1);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {RdIdle, RdWait, RdResp} rd_state_e;
    typedef enum logic [1:0] {WrIdle, WrWait, WrResp} wr_state_e;

    logic [DATA_WIDTH-1:0] mem [0:WORDS-1];

    // ---------------- read channel ----------------
    rd_state_e             rd_state, rd_state_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [3:0]            rd_cnt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;
    logic [ADDR_WIDTH-1:0] rd_off;
    logic                  rd_in_range;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_fire;
    logic                  rd_sample;

    assign rd_off      = rd_addr - BASE_ADDR;
    assign rd_in_range = (rd_addr >= BASE_ADDR) && ({1'b0, rd_off} < SPAN);
    assign rd_idx      = rd_off[DEPTH_LOG2+1:2];

    assign arready_o = (rd_state == RdIdle) && !rst_i;
    assign rd_fire   = arvalid_i && arready_o;
    assign rd_sample = (rd_state == RdWait) && (rd_cnt == 4'd0);

    always_comb begin
        rd_state_nxt = rd_state;
        unique case (rd_state)
            RdIdle:  if (rd_fire) rd_state_nxt = RdWait;
            RdWait:  if (rd_sample) rd_state_nxt = RdResp;
            RdResp:  if (rready_i) rd_state_nxt = RdIdle;
            default: rd_state_nxt = RdIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state <= RdIdle;
            rd_addr  <= '0;
            rd_cnt   <= 4'd0;
            rd_data  <= '0;
            rd_resp  <= RESP_OKAY;
        end else begin
            rd_state <= rd_state_nxt;
            if (rd_fire) begin
                rd_addr <= araddr_i;
                rd_cnt  <= RD_CNT_INIT;
            end else if (rd_state == RdWait && rd_cnt != 4'd0) begin
                rd_cnt <= rd_cnt - 4'd1;
            end
            // Non-blocking read of mem: a commit on this same edge is not yet visible.
            if (rd_sample) begin
                rd_data <= rd_in_range ? mem[rd_idx] : '0;
                rd_resp <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign rvalid_o = (rd_state == RdResp);
    assign rdata_o  = rd_data;
    assign rresp_o  = rd_resp;

    // ---------------- write channel ----------------
    wr_state_e             wr_state, wr_state_nxt;
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [3:0]            wr_strb;
    logic [3:0]            wr_cnt;
    logic [1:0]            wr_resp;
    logic [ADDR_WIDTH-1:0] wr_off;
    logic                  wr_in_range;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic                  aw_fire, w_fire, wr_start, wr_commit;

    assign wr_off      = wr_addr - BASE_ADDR;
    assign wr_in_range = (wr_addr >= BASE_ADDR) && ({1'b0, wr_off} < SPAN);
    assign wr_idx      = wr_off[DEPTH_LOG2+1:2];

    assign awready_o = (wr_state == WrIdle) && !aw_held && !rst_i;
    assign wready_o  = (wr_state == WrIdle) && !w_held && !rst_i;
    assign aw_fire   = awvalid_i && awready_o;
    assign w_fire    = wvalid_i && wready_o;
    assign wr_start  = (wr_state == WrIdle) && (aw_held || aw_fire) && (w_held || w_fire);
    assign wr_commit = (wr_state == WrWait) && (wr_cnt == 4'd0);

    always_comb begin
        wr_state_nxt = wr_state;
        unique case (wr_state)
            WrIdle:  if (wr_start) wr_state_nxt = WrWait;
            WrWait:  if (wr_commit) wr_state_nxt = WrResp;
            WrResp:  if (bready_i) wr_state_nxt = WrIdle;
            default: wr_state_nxt = WrIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state <= WrIdle;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_strb  <= 4'd0;
            wr_cnt   <= 4'd0;
            wr_resp  <= RESP_OKAY;
        end else begin
            wr_state <= wr_state_nxt;
            if (aw_fire) begin
                wr_addr <= awaddr_i;
                aw_held <= 1'b1;
            end
            if (w_fire) begin
                wr_data <= wdata_i;
                wr_strb <= wstrb_i;
                w_held  <= 1'b1;
            end
            if (wr_start) begin
                wr_cnt <= WR_CNT_INIT;
            end else if (wr_state == WrWait && wr_cnt != 4'd0) begin
                wr_cnt <= wr_cnt - 4'd1;
            end
            if (wr_commit) begin
                wr_resp <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
            if (wr_state == WrResp && bready_i) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Array is deliberately outside the reset domain so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (wr_commit && wr_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign bvalid_o = (wr_state == WrResp);
    assign bresp_o  = wr_resp;

endmodule

// File: tb/tb_axil_sram_slave.sv
// Self-checking bench for axil_sram_slave: directed scenarios plus randomized traffic checked
// against a word-array reference model.
module tb_axil_sram_slave;

    localparam int unsigned DEPTH_LOG2 = 6;
    localparam int unsigned WORDS      = 2 ** DEPTH_LOG2;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned WR_LAT     = 2;
    localparam logic [31:0] BASE       = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    axil_sram_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .BASE_ADDR  (BASE),
        .RD_LAT     (RD_LAT),
        .WR_LAT     (WR_LAT)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .araddr_i  (araddr),
        .arvalid_i (arvalid),
        .arready_o (arready),
        .rdata_o   (rdata),
        .rresp_o   (rresp),
        .rvalid_o  (rvalid),
        .rready_i  (rready),
        .awaddr_i  (awaddr),
        .awvalid_i (awvalid),
        .awready_o (awready),
        .wdata_i   (wdata),
        .wstrb_i   (wstrb),
        .wvalid_i  (wvalid),
        .wready_o  (wready),
        .bresp_o   (bresp),
        .bvalid_o  (bvalid),
        .bready_i  (bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [WORDS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        longint unsigned x;
        x = a;
        return (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * WORDS);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        int n;
        bit acc, got;
        int st;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0; acc = 0;
        while (!acc && n < 50) begin
            @(negedge clk); acc = arready;
            @(posedge clk); #1; n++;
        end
        arvalid = 1'b0; st = cyc;
        chk("ar_accept", {31'b0, acc}, 32'd1);
        got = 0; n = 0; data = 'x; resp = 'x; lat = -1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (rvalid) begin got = 1; data = rdata; resp = rresp; lat = cyc - st; end
            @(posedge clk); #1; n++;
        end
        rready = 1'b0;
        chk("r_timeout", {31'b0, got}, 32'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp, output int lat);
        int n;
        bit a, w, got;
        int st;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            @(negedge clk); a = awvalid && awready; w = wvalid && wready;
            @(posedge clk); #1;
            if (a) awvalid = 1'b0;
            if (w) wvalid = 1'b0;
            n++;
        end
        chk("aw_w_accept", {31'b0, !(awvalid || wvalid)}, 32'd1);
        awvalid = 1'b0; wvalid = 1'b0; st = cyc;
        got = 0; n = 0; resp = 'x; lat = -1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (bvalid) begin got = 1; resp = bresp; lat = cyc - st; end
            @(posedge clk); #1; n++;
        end
        bready = 1'b0;
        chk("b_timeout", {31'b0, got}, 32'd1);
    endtask

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        if (in_rng(addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) model[widx(addr)][8*i +: 8] = data[8*i +: 8];
            end
        end
    endfunction

    task automatic check_read(input logic [31:0] addr, input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        do_read(addr, d, r, lat);
        chk({tag, "_rdata"}, d, in_rng(addr) ? model[widx(addr)] : 32'h0);
        chk({tag, "_rresp"}, {30'b0, r}, in_rng(addr) ? 32'd0 : 32'd2);
        chk({tag, "_rlat"}, lat, RD_LAT);
    endtask

    task automatic check_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input string tag);
        logic [1:0] r;
        int         lat;
        do_write(addr, data, strb, r, lat);
        chk({tag, "_bresp"}, {30'b0, r}, in_rng(addr) ? 32'd0 : 32'd2);
        chk({tag, "_blat"}, lat, WR_LAT);
        model_write(addr, data, strb);
    endtask

    initial begin
        logic [31:0] d, old_v, new_v, sum_dut, sum_mod, a;
        logic [1:0]  r;
        int          lat, n, st;
        bit          gr, gb, saw;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", {31'b0, arready}, 0);
        chk("rst_awready", {31'b0, awready}, 0);
        chk("rst_wready", {31'b0, wready}, 0);
        chk("rst_rvalid", {31'b0, rvalid}, 0);
        chk("rst_bvalid", {31'b0, bvalid}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_resps", {28'b0, rresp, bresp}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_readies", {29'b0, arready, awready, wready}, 32'd7);

        // Preload the whole array
        for (int i = 0; i < WORDS; i++) check_write(BASE + 4 * i, $urandom, 4'hF, "preload");
        check_write(BASE, 32'hDEAD_BEEF, 4'hF, "pre_w0");
        check_write(BASE + 4, 32'hAABB_CCDD, 4'hF, "pre_w1");

        // Basic read: latency, data, arready back next cycle
        do_read(BASE, d, r, lat);
        chk("rd0_data", d, 32'hDEAD_BEEF);
        chk("rd0_resp", {30'b0, r}, 0);
        chk("rd0_lat", lat, 2);
        chk("rd0_arready_next", {31'b0, arready}, 1);

        // AW first, W two cycles later, partial strobe
        awaddr = BASE + 4; awvalid = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("split_aw_held", {31'b0, awready}, 0);
        chk("split_w_open", {31'b0, wready}, 1);
        @(posedge clk); #1;
        wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0; st = cyc;
        chk("split_w_taken", {31'b0, wready}, 0);
        gb = 0; n = 0; lat = -1; r = 'x;
        while (!gb && n < 50) begin
            @(negedge clk);
            if (bvalid) begin gb = 1; lat = cyc - st; r = bresp; end
            @(posedge clk); #1; n++;
        end
        bready = 1'b0;
        chk("split_b_seen", {31'b0, gb}, 1);
        chk("split_blat", lat, 2);
        chk("split_bresp", {30'b0, r}, 0);
        model_write(BASE + 4, 32'h1122_3344, 4'b0101);
        do_read(BASE + 4, d, r, lat);
        chk("split_readback", d, 32'hAA22_CC44);

        // Out-of-range accesses and checksum
        check_read(BASE - 4, "oor_rd");
        check_write(BASE + 4 * WORDS, 32'hFFFF_FFFF, 4'hF, "oor_wr");
        sum_dut = 0; sum_mod = 0;
        for (int i = 0; i < WORDS; i++) begin
            do_read(BASE + 4 * i, d, r, lat);
            sum_dut += d;
            sum_mod += model[i];
        end
        chk("checksum", sum_dut, sum_mod);

        // Back-pressure on R: outputs stable, no new AR acceptance
        araddr = BASE + 36; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        gr = 0; n = 0;
        while (!gr && n < 20) begin
            @(negedge clk); gr = rvalid;
            n++;
        end
        chk("bp_rvalid_rose", {31'b0, gr}, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); @(negedge clk);
            chk("bp_rvalid", {31'b0, rvalid}, 1);
            chk("bp_rdata", rdata, model[9]);
            chk("bp_rresp", {30'b0, rresp}, 0);
            chk("bp_arready", {31'b0, arready}, 0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk("bp_done_rvalid", {31'b0, rvalid}, 0);
        chk("bp_done_arready", {31'b0, arready}, 1);

        // Coincident read-sample and write-commit on one word
        old_v = model[7]; new_v = ~old_v;
        araddr = BASE + 28; awaddr = BASE + 28; wdata = new_v; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        gr = 0; gb = 0; n = 0; d = 'x; r = 'x;
        while (!(gr && gb) && n < 50) begin
            @(negedge clk);
            if (rvalid && !gr) begin gr = 1; d = rdata; end
            if (bvalid && !gb) begin gb = 1; r = bresp; end
            @(posedge clk); #1; n++;
        end
        rready = 1'b0; bready = 1'b0;
        chk("same_edge_done", {30'b0, gr, gb}, 32'd3);
        chk("same_edge_old", d, old_v);
        chk("same_edge_bresp", {30'b0, r}, 0);
        model[7] = new_v;
        check_read(BASE + 28, "same_edge_new");

        // Reset during R_WAIT and W_WAIT
        araddr = BASE + 8; awaddr = BASE + 12; wdata = ~model[3]; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_readies", {29'b0, arready, awready, wready}, 0);
        chk("midrst_valids", {30'b0, rvalid, bvalid}, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_readies_hold", {29'b0, arready, awready, wready}, 0);
        rst = 1'b0;
        #1;
        chk("midrst_readies_after", {29'b0, arready, awready, wready}, 32'd7);
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid || bvalid) saw = 1;
        end
        rready = 1'b0; bready = 1'b0;
        chk("midrst_no_response", {31'b0, saw}, 0);
        check_read(BASE + 12, "midrst_dropped_wr");
        check_read(BASE + 8, "midrst_new_rd");
        check_write(BASE + 12, 32'h0BAD_F00D, 4'b1001, "midrst_new_wr");
        check_read(BASE + 12, "midrst_new_rb");

        // Randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            n = $urandom_range(0, 9);
            if (n == 0) a = BASE - 4 * $urandom_range(1, 4);
            else if (n == 1) a = BASE + 4 * WORDS + 4 * $urandom_range(0, 3);
            else a = BASE + 4 * $urandom_range(0, WORDS - 1) + $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                check_write(a, $urandom, 4'($urandom_range(0, 15)), "rnd_wr");
            end else begin
                check_read(a, "rnd_rd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
